// File: rtl/nic_counter_sequencer.sv
// ---------------------------------------------------------------------------
// nic_counter_sequencer
//
// Owns the read port of the NIC statistics counter block and shares it
// between single host CSR reads and a sweep engine that walks every counter
// in order for telemetry dumps. Contending requesters are granted
// round-robin, so each side waits for at most one transaction of the other.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   host_req_valid/id/ready      host read request handshake
//   host_rsp_valid/value/error   one-cycle host response (value 0 on error)
//   sweep_start                  pulse that arms a full sweep
//   sweep_busy                   sweep armed or in progress
//   sweep_valid/ready/id/value   sweep element stream (held while stalled)
//   sweep_done                   pulse after the last element is accepted
//   counter_id_out               registered counter select
//   counter_value_in             counter value, READ_LATENCY after select
// ---------------------------------------------------------------------------
module nic_counter_sequencer #(
  parameter int NUM_COUNTERS = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        host_req_valid,
  input  logic [7:0]  host_req_id,
  output logic        host_req_ready,
  output logic        host_rsp_valid,
  output logic [63:0] host_rsp_value,
  output logic        host_rsp_error,
  input  logic        sweep_start,
  output logic        sweep_busy,
  output logic        sweep_valid,
  input  logic        sweep_ready,
  output logic [7:0]  sweep_id,
  output logic [63:0] sweep_value,
  output logic        sweep_done,
  output logic [7:0]  counter_id_out,
  input  logic [63:0] counter_value_in
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HRSP, S_SOUT} state_t;

  localparam logic [7:0] LAST_ID     = 8'(NUM_COUNTERS - 1);
  localparam logic [8:0] NUM_IDS     = 9'(NUM_COUNTERS);
  localparam logic [2:0] LAT         = 3'(READ_LATENCY);
  localparam logic       GRANT_HOST  = 1'b0;
  localparam logic       GRANT_SWEEP = 1'b1;

  state_t      r_state;
  state_t      w_state_next;
  logic        r_last_grant;
  logic        r_owner_host;    // requester of the read currently in WAIT
  logic        r_sweep_busy;
  logic        r_sweep_done;
  logic        r_rsp_error;
  logic [7:0]  r_sweep_idx;
  logic [7:0]  r_counter_id;
  logic [7:0]  r_sweep_id;
  logic [2:0]  r_wait_cnt;
  logic [63:0] r_host_value;
  logic [63:0] r_sweep_value;

  logic        w_grant_host;
  logic        w_grant_sweep;
  logic        w_id_in_range;
  logic        w_sweep_accept;

  assign w_id_in_range  = ({1'b0, host_req_id} < NUM_IDS);
  assign w_sweep_accept = (r_state == S_SOUT) && sweep_ready;

  // Arbitration and next state. The host wins when the sweep is idle or
  // when the sweep had the previous slot.
  always_comb begin
    w_state_next  = r_state;
    w_grant_host  = 1'b0;
    w_grant_sweep = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (host_req_valid && (!r_sweep_busy || r_last_grant == GRANT_SWEEP)) begin
          w_grant_host = 1'b1;
          w_state_next = w_id_in_range ? S_WAIT : S_HRSP;
        end else if (r_sweep_busy) begin
          w_grant_sweep = 1'b1;
          w_state_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_wait_cnt == 3'd0) begin
          w_state_next = r_owner_host ? S_HRSP : S_SOUT;
        end
      end
      S_HRSP: w_state_next = S_IDLE;
      S_SOUT: begin
        if (sweep_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_grant  <= GRANT_SWEEP;
      r_owner_host  <= 1'b0;
      r_sweep_busy  <= 1'b0;
      r_sweep_done  <= 1'b0;
      r_rsp_error   <= 1'b0;
      r_sweep_idx   <= 8'd0;
      r_counter_id  <= 8'd0;
      r_sweep_id    <= 8'd0;
      r_wait_cnt    <= 3'd0;
      r_host_value  <= 64'd0;
      r_sweep_value <= 64'd0;
    end else begin
      r_sweep_done <= 1'b0;

      if (w_grant_host) begin
        r_last_grant <= GRANT_HOST;
        r_owner_host <= 1'b1;
        if (w_id_in_range) begin
          r_counter_id <= host_req_id;
          r_wait_cnt   <= LAT;
        end else begin
          // Out-of-range IDs never touch the counter block.
          r_rsp_error  <= 1'b1;
          r_host_value <= 64'd0;
        end
      end

      if (w_grant_sweep) begin
        r_last_grant <= GRANT_SWEEP;
        r_owner_host <= 1'b0;
        r_counter_id <= r_sweep_idx;
        r_wait_cnt   <= LAT;
      end

      // The counter value is first valid READ_LATENCY edges after the select
      // changes, so it is captured one edge after the count reaches zero.
      if (r_state == S_WAIT) begin
        if (r_wait_cnt != 3'd0) begin
          r_wait_cnt <= r_wait_cnt - 3'd1;
        end else if (r_owner_host) begin
          r_host_value <= counter_value_in;
          r_rsp_error  <= 1'b0;
        end else begin
          r_sweep_value <= counter_value_in;
          r_sweep_id    <= r_sweep_idx;
        end
      end

      if (w_sweep_accept) begin
        if (r_sweep_idx == LAST_ID) begin
          r_sweep_done <= 1'b1;
          r_sweep_busy <= 1'b0;
          r_sweep_idx  <= 8'd0;
        end else begin
          r_sweep_idx <= r_sweep_idx + 8'd1;
        end
      end else if (sweep_start && !r_sweep_busy && !r_sweep_done) begin
        // A start coinciding with the done pulse does not re-arm the sweep.
        r_sweep_busy <= 1'b1;
      end
    end
  end

  assign host_req_ready = w_grant_host;
  assign host_rsp_valid = (r_state == S_HRSP);
  assign host_rsp_value = r_host_value;
  assign host_rsp_error = r_rsp_error;
  assign sweep_busy     = r_sweep_busy;
  assign sweep_valid    = (r_state == S_SOUT);
  assign sweep_id       = r_sweep_id;
  assign sweep_value    = r_sweep_value;
  assign sweep_done     = r_sweep_done;
  assign counter_id_out = r_counter_id;

endmodule
